// File: rtl/indication_arb_pkg.sv
// Shared message layout and pointer helper for indication_pipe_arbiter.
// A message word is {v, meth, tag}, most significant field first.
package indication_arb_pkg;

  localparam int MSG_WIDTH  = 96;
  localparam int TAG_WIDTH  = 32;
  localparam int METH_WIDTH = 32;
  localparam int V_WIDTH    = 32;

  typedef struct packed {
    logic [V_WIDTH-1:0]    v;
    logic [METH_WIDTH-1:0] meth;
    logic [TAG_WIDTH-1:0]  tag;
  } msg_t;

  // Successor of idx in a ring of n positions.
  function automatic int next_ptr(input int idx, input int n);
    if (idx >= n - 32'sd1) begin
      return 32'sd0;
    end else begin
      return idx + 32'sd1;
    end
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr,
// wrapping modulo N. Returns one-hot grant, its index and an any flag.
module rr_pick #(
  parameter int N  = 4,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [PW-1:0] index,
  output logic          any
);

  int pos;

  // Scan the ring starting at ptr; the first hit wins.
  always_comb begin
    grant = '0;
    index = '0;
    any   = 1'b0;
    pos   = 32'sd0;
    for (int k = 0; k < N; k++) begin
      pos = (int'(ptr) + k >= N) ? (int'(ptr) + k - N) : (int'(ptr) + k);
      if (!any && req[pos]) begin
        any        = 1'b1;
        index      = PW'(pos);
        grant[pos] = 1'b1;
      end else begin
        any = any;
      end
    end
  end

endmodule

// File: rtl/indication_pipe_arbiter.sv
// Shares one indication pipe between NREQ requesters through one-entry slots
// and a round-robin loaded output register. Optional grant trace: INDICATION_ARB_TRACE_EN.
module indication_pipe_arbiter
  import indication_arb_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int WIDTH = MSG_WIDTH
) (
  input  logic                  CLK,
  input  logic                  nRST,
  input  logic [NREQ-1:0]       req_enq__ENA,
  input  logic [NREQ*WIDTH-1:0] req_enq_v,
  output logic [NREQ-1:0]       req_enq__RDY,
  output logic                  pipe_enq__ENA,
  output logic [WIDTH-1:0]      pipe_enq_v,
  input  logic                  pipe_enq__RDY
);

  localparam int PW = $clog2(NREQ);

  logic [WIDTH-1:0] slot_data_r [NREQ];
  logic [NREQ-1:0]  slot_full_r;
  logic [WIDTH-1:0] out_data_r;
  logic             out_valid_r;
  logic [PW-1:0]    rr_ptr_r;

  logic [NREQ-1:0]  accept_s;
  logic [NREQ-1:0]  pick_grant_s;
  logic [PW-1:0]    pick_idx_s;
  logic             pick_any_s;
  logic             can_load_s;
  logic             load_s;

  // Ready depends only on slot state, never on the downstream ready.
  assign req_enq__RDY  = ~slot_full_r;
  assign accept_s      = req_enq__ENA & ~slot_full_r;
  assign can_load_s    = ~out_valid_r | pipe_enq__RDY;
  assign load_s        = can_load_s & pick_any_s;
  assign pipe_enq__ENA = out_valid_r;
  assign pipe_enq_v    = out_valid_r ? out_data_r : {WIDTH{1'b0}};

  rr_pick #(
    .N  (NREQ),
    .PW (PW)
  ) u_pick (
    .req   (slot_full_r),
    .ptr   (rr_ptr_r),
    .grant (pick_grant_s),
    .index (pick_idx_s),
    .any   (pick_any_s)
  );

  // Holding slots: capture on accept, release when granted.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      slot_full_r <= '0;
      for (int i = 0; i < NREQ; i++) begin
        slot_data_r[i] <= '0;
      end
    end else begin
      slot_full_r <= (slot_full_r & ~(pick_grant_s & {NREQ{load_s}})) | accept_s;
      for (int i = 0; i < NREQ; i++) begin
        if (accept_s[i]) begin
          slot_data_r[i] <= req_enq_v[i*WIDTH +: WIDTH];
        end else begin
          slot_data_r[i] <= slot_data_r[i];
        end
      end
    end
  end

  // Output register and round-robin pointer; a drain and a load may coincide.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      out_valid_r <= 1'b0;
      out_data_r  <= '0;
      rr_ptr_r    <= '0;
    end else if (load_s) begin
      out_valid_r <= 1'b1;
      out_data_r  <= slot_data_r[pick_idx_s];
      rr_ptr_r    <= PW'(next_ptr(int'(pick_idx_s), NREQ));
    end else if (can_load_s) begin
      out_valid_r <= 1'b0;
      out_data_r  <= '0;
      rr_ptr_r    <= rr_ptr_r;
    end else begin
      out_valid_r <= out_valid_r;
      out_data_r  <= out_data_r;
      rr_ptr_r    <= rr_ptr_r;
    end
  end

`ifdef INDICATION_ARB_TRACE_EN
  // Grant trace, printing the tag of the word being loaded.
  always_ff @(posedge CLK) begin
    if (nRST && load_s) begin
      $display("[indication_pipe_arbiter] grant %d tag %d", pick_idx_s,
               slot_data_r[pick_idx_s][31:0]);
    end else begin
    end
  end
`endif

endmodule
